stream_sort: RTL
================

# stream_sort

Parametrised sequential sorter generalising the team's combinational 8-bit `sort` block. It accepts a batch of `N` words of `W` bits over a valid/ready input stream and sorts them in place with odd-even transposition, one compare-exchange pass per clock. It then emits the sorted batch over a valid/ready output stream. It sits between a sample producer and any consumer needing ordered batches (median/rank filters).

## Interface
- `W`, 8: data word width in bits (≥1).
- `N`, 8: words per batch; even, ≥2.
- `CW`, `$clog2(N+1)`: internal counter width (derived, not overridden).

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  input word present.
- `in_ready`  output  1  block accepts input (high only in LOAD).
- `in_data`  input  W  input word.
- `out_valid`  output  1  sorted word present (high only in DRAIN).
- `out_ready`  input  1  consumer accepts output word.
- `out_data`  output  W  sorted word.
- `out_last`  output  1  marks final word of batch.
- `busy`  output  1  high in SORT or DRAIN.

## Operation
- Storage: register array `r[0..N-1]`, counter `cnt` (CW bits), state {LOAD, SORT, DRAIN}.
- LOAD: `in_ready`=1. On `in_valid && in_ready`, `r[cnt] <= in_data`, `cnt++`. On accepting word `N-1`, go to SORT with `cnt`=0.
- SORT: `in_ready`=0, `out_valid`=0. Pass `cnt` even compares pairs (0,1),(2,3)…(N-2,N-1). Pass `cnt` odd compares pairs (1,2),(3,4)…(N-3,N-2). All pairs are evaluated in parallel from pre-pass values. Swap when `r[i] > r[i+1]`, unsigned; equal values are never swapped. After exactly `N` passes (`cnt`=N-1 completing), go to DRAIN with `cnt`=0. There is no early exit.
- DRAIN: `out_valid`=1, `out_data`=`r[cnt]`, `out_last`=(`cnt`==N-1). On `out_valid && out_ready`, `cnt++`. After the handshake with `out_last`=1, go to LOAD with `cnt`=0.
- `in_valid` outside LOAD is ignored; no data is captured.
- While `out_ready`=0, `out_valid`, `out_data` and `out_last` hold stable.
- Reset (any state, any time): state=LOAD, `cnt`=0, `r[*]`=0. A partial or in-flight batch is discarded silently.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
- All outputs are decoded from registered state and `r[cnt]`; there is no combinational path from `in_valid` or `out_ready` to any output.
- Last input handshake at edge `t` → SORT during cycles `t+1 … t+N` → `out_valid` high after edge `t+N`.
- Input-to-first-output latency is `N+1` cycles after the final input handshake, independent of data.
- Full output drain with `out_ready` held high takes `N` cycles. `in_ready` rises the cycle after the last output handshake.
- Throughput, continuous streams: one batch per `3N+1` cycles.
- Back-to-back: a new batch cannot load while DRAIN is in progress; the producer sees `in_ready`=0.

## Configuration
- `STREAM_SORT_DESCEND_EN` defined: the comparison becomes `r[i] < r[i+1]`, so output is non-increasing. Equal values are still never swapped.
- Not defined: output is non-decreasing (ascending).
- Latency, handshakes and reset behaviour are identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs → `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
- N=8, W=8: stream 5,3,8,1,9,2,7,4 with `out_ready`=1 → outputs 1,2,3,4,5,7,8,9; `out_last` only with 9; first `out_valid` exactly 9 cycles after the last input handshake.
- Worst case and duplicates: stream 255,254,…,248 → 248…255. Stream 6,6,0,6,0,0,6,0 → 0,0,0,0,6,6,6,6. Stream all-0x5A → eight 0x5A.
- Backpressure: toggle `out_ready` pseudo-randomly during DRAIN → `out_data` and `out_last` stable while stalled, no word lost or duplicated. `in_valid`=1 during SORT/DRAIN is not captured.
- Reset mid-operation: assert `rst_n`=0 at SORT pass 3, then load 1..8 reversed → clean output 1..8, no remnants of the aborted batch.
- `STREAM_SORT_DESCEND_EN` build: stream 5,3,8,1,9,2,7,4 → 9,8,7,5,4,3,2,1 with identical latency.

Source files
------------

// File: rtl/stream_sort_if.sv
// Valid/ready handshake bundle for stream_sort: input word stream, sorted output stream and busy flag.
interface stream_sort_if #(
    parameter int W = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/stream_sort.sv
// Batch sorter: loads N words, runs N odd-even transposition passes, drains the sorted batch.
// Define STREAM_SORT_DESCEND_EN for non-increasing output order (ascending otherwise).
//
// state | meaning
// LOAD  | accepting words into r[cnt]
// SORT  | one compare-exchange pass per clock, pass parity = cnt[0]
// DRAIN | presenting r[cnt] on the output stream
module stream_sort #(
    parameter  int W  = 8,
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input logic          clk,
    input logic          rst_n,
    stream_sort_if.slave s
);
    localparam int IW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   r      [N];
    logic [W-1:0]   r_pass [N];
    logic           in_ready_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic           busy_q;
    logic [IW-1:0]  idx;

    assign idx = cnt[IW-1:0];

    function automatic logic out_of_order(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef STREAM_SORT_DESCEND_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    // Pairs are disjoint within a pass, so every exchange reads pre-pass values.
    always_comb begin
        r_pass = r;
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2) == int'(cnt[0]) && out_of_order(r[i], r[i+1])) begin
                r_pass[i]   = r[i+1];
                r_pass[i+1] = r[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < N; i++) r[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (s.in_valid) begin
                        r[idx] <= s.in_data;
                        if (cnt == CW'(N - 1)) begin
                            state      <= SORT;
                            cnt        <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SORT: begin
                    r <= r_pass;
                    if (cnt == CW'(N - 1)) begin
                        state       <= DRAIN;
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (s.out_ready) begin
                        if (cnt == CW'(N - 1)) begin
                            state       <= LOAD;
                            cnt         <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            cnt        <= cnt + 1'b1;
                            out_last_q <= (cnt == CW'(N - 2));
                        end
                    end
                end
                default: begin
                    state       <= LOAD;
                    cnt         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.busy      = busy_q;
    assign s.out_data  = r[idx];
endmodule
